// File: rtl/ascon_io_pkg.sv
// ascon_io_pkg
// Shared types and helpers for the Ascon serial stream wrapper:
//   state_t  - controller state encoding
//   cnt_w()  - width of a counter that must hold the values 0..n
//   max4()   - largest of four lengths, used to size the shared load count
package ascon_io_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_t;

    localparam int unsigned NONCE_BITS = 128;
    localparam int unsigned TAG_BITS   = 128;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ascon_stream_io_if.sv
// ascon_stream_io_if
// Serial stream side of the Ascon wrapper.
//   key_i/nonce_i/ad_i/pt_i, in_valid, in_ready : MSB-first input beats
//   start_i, busy_o                              : encryption request / status
//   ct_o/ct_valid, tag_o/tag_valid, out_ready    : LSB-first result beats
//   done_o                                       : end-of-operation pulse
// slave = the wrapper, master = whoever feeds and drains it.
interface ascon_stream_io_if #(
    parameter int unsigned W = 1
) ();
    logic [W-1:0] key_i;
    logic [W-1:0] nonce_i;
    logic [W-1:0] ad_i;
    logic [W-1:0] pt_i;
    logic         in_valid;
    logic         in_ready;
    logic         start_i;
    logic         busy_o;
    logic [W-1:0] ct_o;
    logic         ct_valid;
    logic [W-1:0] tag_o;
    logic         tag_valid;
    logic         out_ready;
    logic         done_o;

    modport slave (
        input  key_i, nonce_i, ad_i, pt_i, in_valid, start_i, out_ready,
        output in_ready, busy_o, ct_o, ct_valid, tag_o, tag_valid, done_o
    );

    modport master (
        output key_i, nonce_i, ad_i, pt_i, in_valid, start_i, out_ready,
        input  in_ready, busy_o, ct_o, ct_valid, tag_o, tag_valid, done_o
    );
endinterface

// File: rtl/ascon_shift_reg.sv
// ascon_shift_reg
// LEN-bit register, W bits per shift. Shifts toward the MSB, new beat enters
// at the LSB end, serial output is the top W bits. Parallel load wins over shift.
//   clk, rst       : clock, async active-low reset (clears to 0)
//   shift_en_i     : shift one beat
//   load_en_i      : parallel load from load_data_i
//   ser_i / ser_o  : serial in (LSB end) / serial out (MSB end)
//   par_o          : full register contents
module ascon_shift_reg #(
    parameter int unsigned LEN = 32,
    parameter int unsigned W   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift_en_i,
    input  logic           load_en_i,
    input  logic [LEN-1:0] load_data_i,
    input  logic [W-1:0]   ser_i,
    output logic [LEN-1:0] par_o,
    output logic [W-1:0]   ser_o
);
    logic [LEN-1:0] data_q;
    logic [LEN-1:0] shift_d;

    generate
        if (LEN == W) begin : g_single
            assign shift_d = ser_i;
        end else begin : g_multi
            assign shift_d = {data_q[LEN-W-1:0], ser_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (load_en_i) begin
            data_q <= load_data_i;
        end else if (shift_en_i) begin
            data_q <= shift_d;
        end
    end

    assign par_o = data_q;
    assign ser_o = data_q[LEN-1 -: W];
endmodule

// File: rtl/ascon_stream_io.sv
// ascon_stream_io
// Serialises key/nonce/AD/plaintext into an Ascon encryption core and streams
// the ciphertext and tag back out, W bits per beat.
//   clk, rst        : sole clock, async active-low reset
//   io (slave)      : serial stream side, see ascon_stream_io_if
//   core_*_o        : parallel operands and start pulse to the core
//   core_ct_i/tag_i : core results, sampled in CAPTURE
//   core_ready_i    : core has finished
//   op_cnt_o        : completed-operation count, only with ASCON_IO_OPCNT_EN
//
// state   | meaning
// LOAD    | accepting input beats, in_ready high
// ARMED   | operands complete, waiting for start_i
// RUN     | core working, waiting for core_ready_i
// CAPTURE | latch ciphertext and tag into the output shifters
// UNLOAD  | stream ciphertext and tag beats out
module ascon_stream_io
    import ascon_io_pkg::*;
#(
    parameter int unsigned K = 128,
    parameter int unsigned L = 32,
    parameter int unsigned Y = 32,
    parameter int unsigned W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ascon_stream_io_if.slave      io,
    output logic [K-1:0]          core_key_o,
    output logic [NONCE_BITS-1:0] core_nonce_o,
    output logic [L-1:0]          core_ad_o,
    output logic [Y-1:0]          core_pt_o,
    output logic                  core_start_o,
    input  logic [Y-1:0]          core_ct_i,
    input  logic [TAG_BITS-1:0]   core_tag_i,
    input  logic                  core_ready_i
`ifdef ASCON_IO_OPCNT_EN
    ,
    output logic [15:0]           op_cnt_o
`endif
);
    localparam int unsigned KB   = K / W;
    localparam int unsigned NB   = NONCE_BITS / W;
    localparam int unsigned LB   = L / W;
    localparam int unsigned YB   = Y / W;
    localparam int unsigned TB   = TAG_BITS / W;
    localparam int unsigned MAXB = max4(K, NONCE_BITS, L, Y) / W;
    localparam int unsigned LCW  = cnt_w(MAXB);
    localparam int unsigned YCW  = cnt_w(YB);
    localparam int unsigned TCW  = cnt_w(TB);

    generate
        if ((K % W) != 0 || (NONCE_BITS % W) != 0 || (L % W) != 0 || (Y % W) != 0) begin : g_bad_w
            $error("ascon_stream_io: K, 128, L and Y must all be multiples of W");
        end
    endgenerate

    state_t         state_q, state_d;
    logic [LCW-1:0] ld_cnt_q, ld_cnt_d;
    logic [YCW-1:0] ct_cnt_q, ct_cnt_d;
    logic [TCW-1:0] tag_cnt_q, tag_cnt_d;
    logic           done_q, done_d;

    logic           ld_beat, ct_acc, tag_acc, ct_vld, tag_vld;
    logic [W-1:0]   ct_ser, tag_ser;
    logic [W-1:0]   key_ser, nonce_ser, ad_ser, pt_ser;
    logic [Y-1:0]   ct_par;
    logic [TAG_BITS-1:0] tag_par;
    logic [Y-1:0]        ct_beat_rev;
    logic [TAG_BITS-1:0] tag_beat_rev;
    logic           unused_sink;

    assign ld_beat = (state_q == ST_LOAD) && io.in_valid;
    assign ct_vld  = (state_q == ST_UNLOAD) && (ct_cnt_q < YCW'(YB));
    assign tag_vld = (state_q == ST_UNLOAD) && (tag_cnt_q < TCW'(TB));
    assign ct_acc  = ct_vld && io.out_ready;
    assign tag_acc = tag_vld && io.out_ready;

    // Input shifters: each takes only its first LEN/W beats of the shared count.
    ascon_shift_reg #(.LEN(K), .W(W)) u_key (
        .clk(clk), .rst(rst), .shift_en_i(ld_beat && (ld_cnt_q < LCW'(KB))),
        .load_en_i(1'b0), .load_data_i('0), .ser_i(io.key_i),
        .par_o(core_key_o), .ser_o(key_ser));
    ascon_shift_reg #(.LEN(NONCE_BITS), .W(W)) u_nonce (
        .clk(clk), .rst(rst), .shift_en_i(ld_beat && (ld_cnt_q < LCW'(NB))),
        .load_en_i(1'b0), .load_data_i('0), .ser_i(io.nonce_i),
        .par_o(core_nonce_o), .ser_o(nonce_ser));
    ascon_shift_reg #(.LEN(L), .W(W)) u_ad (
        .clk(clk), .rst(rst), .shift_en_i(ld_beat && (ld_cnt_q < LCW'(LB))),
        .load_en_i(1'b0), .load_data_i('0), .ser_i(io.ad_i),
        .par_o(core_ad_o), .ser_o(ad_ser));
    ascon_shift_reg #(.LEN(Y), .W(W)) u_pt (
        .clk(clk), .rst(rst), .shift_en_i(ld_beat && (ld_cnt_q < LCW'(YB))),
        .load_en_i(1'b0), .load_data_i('0), .ser_i(io.pt_i),
        .par_o(core_pt_o), .ser_o(pt_ser));

    // The shifter emits its MSB beat first, so results are loaded with beat
    // order reversed to put beat 0 (bits W-1:0) at the top.
    generate
        for (genvar j = 0; j < YB; j++) begin : g_ct_rev
            assign ct_beat_rev[Y-1-j*W -: W] = core_ct_i[j*W +: W];
        end
        for (genvar j = 0; j < TB; j++) begin : g_tag_rev
            assign tag_beat_rev[TAG_BITS-1-j*W -: W] = core_tag_i[j*W +: W];
        end
    endgenerate

    ascon_shift_reg #(.LEN(Y), .W(W)) u_ct (
        .clk(clk), .rst(rst), .shift_en_i(ct_acc),
        .load_en_i(state_q == ST_CAPTURE), .load_data_i(ct_beat_rev), .ser_i('0),
        .par_o(ct_par), .ser_o(ct_ser));
    ascon_shift_reg #(.LEN(TAG_BITS), .W(W)) u_tag (
        .clk(clk), .rst(rst), .shift_en_i(tag_acc),
        .load_en_i(state_q == ST_CAPTURE), .load_data_i(tag_beat_rev), .ser_i('0),
        .par_o(tag_par), .ser_o(tag_ser));

    assign unused_sink = ^{key_ser, nonce_ser, ad_ser, pt_ser, ct_par, tag_par};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_LOAD;
            ld_cnt_q  <= '0;
            ct_cnt_q  <= '0;
            tag_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            ct_cnt_q  <= ct_cnt_d;
            tag_cnt_q <= tag_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ct_cnt_d  = ct_cnt_q;
        tag_cnt_d = tag_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (io.in_valid) begin
                    if (ld_cnt_q == LCW'(MAXB - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = ST_ARMED;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            ST_ARMED:   if (io.start_i) state_d = ST_RUN;
            ST_RUN:     if (core_ready_i) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_UNLOAD;
            ST_UNLOAD: begin
                if (ct_acc)  ct_cnt_d  = ct_cnt_q + 1'b1;
                if (tag_acc) tag_cnt_d = tag_cnt_q + 1'b1;
                if ((ct_cnt_d == YCW'(YB)) && (tag_cnt_d == TCW'(TB))) begin
                    ct_cnt_d  = '0;
                    tag_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // in_ready is held low while reset is applied even though the state is LOAD.
    assign io.in_ready  = rst && (state_q == ST_LOAD);
    assign io.busy_o    = (state_q == ST_RUN) || (state_q == ST_CAPTURE) || (state_q == ST_UNLOAD);
    assign core_start_o = (state_q == ST_ARMED) && io.start_i;
    assign io.ct_valid  = ct_vld;
    assign io.tag_valid = tag_vld;
    assign io.ct_o      = ct_vld ? ct_ser : '0;
    assign io.tag_o     = tag_vld ? tag_ser : '0;
    assign io.done_o    = done_q;

`ifdef ASCON_IO_OPCNT_EN
    logic [15:0] op_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_cnt_q <= '0;
        end else if (done_d) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end
    assign op_cnt_o = op_cnt_q;
`endif
endmodule
